hazard_ctrl: RTL

Pipeline hazard and pipeline-freeze controller for the 5-stage RV32I core. It consumes the execute-stage outputs of the ID/EX register (PCSrcE, RdE, Rs1E, Rs2E, ResultSrcE) plus the later-stage destination tags. It produces the forwarding selects, stall and flush controls that drive the pipeline registers. A small state machine tracks data-memory wait states with a timeout, and it keeps stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and freeze controller for the 5-stage RV32I pipeline: operand forwarding,
// load-use stall, branch flush, data-memory wait tracking with timeout, perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemAccessM,
    input  logic             mem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WC_W-1:0]   wait_cnt;
    logic [WC_W-1:0]   wait_cnt_next;
    logic              mem_pending;
    logic              freeze;
    logic              lw_stall;

    assign mem_pending = MemAccessM & ~mem_ready;
    assign freeze      = mem_pending | (state == S_ERR);
    assign lw_stall    = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));

    // Operand forwarding; the memory stage holds the younger value and wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    // Stall and flush; a frozen pipeline keeps any redirect parked in EX.
    always_comb begin
        StallF = lw_stall | freeze;
        StallD = lw_stall | freeze;
        StallE = freeze;
        StallM = freeze;
        StallW = freeze;
        FlushD = PCSrcE & ~freeze;
        FlushE = (lw_stall | PCSrcE) & ~freeze;
    end

    // Memory-wait tracker next state; ERR only leaves through rst.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_RUN: begin
                if (mem_pending) begin
                    wait_cnt_next = WC_W'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else begin
                    state_next = S_RUN;
                end
            end
            S_WAIT: begin
                if (mem_pending) begin
                    wait_cnt_next = wait_cnt + WC_W'(1);
                    if (wait_cnt_next == WC_W'(MEM_TIMEOUT)) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else begin
                    state_next    = S_RUN;
                    wait_cnt_next = '0;
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next    = S_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            mem_error <= (state_next == S_ERR);
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (FlushE && PCSrcE) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule
